// File: rtl/dac_update_scheduler.sv
`timescale 1ns/1ps
// dac_update_scheduler
// Keeps a shadow code and a dirty bit for every LTC2656 channel. Each frame
// tick (periodic timer or flush) walks the dirty channels in ascending order,
// hands one write-input-register command per channel to the SPI driver using
// its start/idle handshake, then pulses LDAC once so every channel updates
// together.
module dac_update_scheduler #(
   parameter int         NUM_CH        = 8,
   parameter int         PERIOD_CYCLES = 100000,
   parameter logic [3:0] CMD_WRITE     = 4'h0
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        enable,
   input  logic        flush,
   input  logic        wr_valid,
   input  logic [3:0]  wr_channel,
   input  logic [15:0] wr_value,
   output logic        wr_err,
   input  logic        drv_idle,
   output logic [3:0]  drv_cmd,
   output logic [3:0]  drv_channel,
   output logic [15:0] drv_value,
   output logic        drv_start,
   output logic        drv_ldac,
   output logic        busy,
   output logic [7:0]  dirty_mask,
   output logic [15:0] frame_count,
   output logic        overrun
);

   localparam int             TW           = $clog2(PERIOD_CYCLES);
   localparam logic [TW-1:0]  TIMER_RELOAD = TW'(PERIOD_CYCLES - 1);
   localparam logic [2:0]     LAST_PTR     = 3'(NUM_CH - 1);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] SCAN  = 3'd1;
   localparam logic [2:0] ISSUE = 3'd2;
   localparam logic [2:0] GAP   = 3'd3;
   localparam logic [2:0] WAIT  = 3'd4;
   localparam logic [2:0] LDAC  = 3'd5;

   logic [2:0]    r_state;
   logic [2:0]    r_ptr;
   logic          r_issued;
   logic          r_pending;
   logic [TW-1:0] r_timer;
   logic [7:0]    r_dirty;
   logic [15:0]   r_shadow [8];
   logic [3:0]    r_drvCmd;
   logic [3:0]    r_drvChannel;
   logic [15:0]   r_drvValue;
   logic          r_drvStart;
   logic          r_drvLdac;
   logic [15:0]   r_frameCount;
   logic          r_overrun;
   logic          r_wrErr;

   logic w_wrHit;
   logic w_tick;
   logic w_consume;

   // A write lands only on channels that exist; a periodic tick and a flush in
   // the same cycle merge into one tick; IDLE consumes the pending tick.
   always_comb begin
      w_wrHit   = wr_valid && (wr_channel < 4'(NUM_CH));
      w_tick    = (enable && (r_timer == '0)) || flush;
      w_consume = (r_state == IDLE) && r_pending;
   end

   // Frame timer: counts down while enabled, reloads on expiry or when disabled.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_timer <= TIMER_RELOAD;
      end else if (!enable || (r_timer == '0)) begin
         r_timer <= TIMER_RELOAD;
      end else begin
         r_timer <= r_timer - TW'(1);
      end
   end

   // One-deep tick queue; a tick arriving while one is still queued is an overrun.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_pending <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_overrun <= w_tick && r_pending && !w_consume;
         if (w_tick) begin
            r_pending <= 1'b1;
         end else if (w_consume) begin
            r_pending <= 1'b0;
         end
      end
   end

   // Shadow/dirty storage; a write to the channel being issued wins over the clear,
   // so the fresh value is kept dirty for the next frame.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int i = 0; i < 8; i++) begin
            r_shadow[i] <= 16'h0000;
         end
         r_dirty <= 8'h00;
         r_wrErr <= 1'b0;
      end else begin
         r_wrErr <= wr_valid && !w_wrHit;
         if (r_state == ISSUE) begin
            r_dirty[r_ptr] <= 1'b0;
         end
         if (w_wrHit) begin
            r_shadow[wr_channel[2:0]] <= wr_value;
            r_dirty[wr_channel[2:0]]  <= 1'b1;
         end
      end
   end

   // Frame walker: scans channels, drives the driver handshake and finishes with LDAC.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state      <= IDLE;
         r_ptr        <= 3'd0;
         r_issued     <= 1'b0;
         r_drvCmd     <= 4'h0;
         r_drvChannel <= 4'h0;
         r_drvValue   <= 16'h0000;
         r_drvStart   <= 1'b0;
         r_drvLdac    <= 1'b0;
         r_frameCount <= 16'h0000;
      end else begin
         r_drvStart <= 1'b0;
         r_drvLdac  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (r_pending) begin
                  r_issued <= 1'b0;
                  if (r_dirty != 8'h00) begin
                     r_ptr   <= 3'd0;
                     r_state <= SCAN;
                  end
               end
            end
            SCAN: begin
               if (r_dirty[r_ptr]) begin
                  if (drv_idle) begin
                     r_drvCmd     <= CMD_WRITE;
                     r_drvChannel <= {1'b0, r_ptr};
                     r_drvValue   <= r_shadow[r_ptr];
                     r_drvStart   <= 1'b1;
                     r_state      <= ISSUE;
                  end
               end else if (r_ptr == LAST_PTR) begin
                  r_state <= r_issued ? LDAC : IDLE;
               end else begin
                  r_ptr <= r_ptr + 3'd1;
               end
            end
            ISSUE: begin
               r_issued <= 1'b1;
               r_state  <= GAP;
            end
            GAP: begin
               r_state <= WAIT;
            end
            WAIT: begin
               if (drv_idle) begin
                  if (r_ptr == LAST_PTR) begin
                     r_state <= LDAC;
                  end else begin
                     r_ptr   <= r_ptr + 3'd1;
                     r_state <= SCAN;
                  end
               end
            end
            LDAC: begin
               if (drv_idle) begin
                  r_drvLdac    <= 1'b1;
                  r_frameCount <= r_frameCount + 16'd1;
                  r_state      <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   // Output mapping; busy reflects any state other than IDLE.
   always_comb begin
      wr_err      = r_wrErr;
      drv_cmd     = r_drvCmd;
      drv_channel = r_drvChannel;
      drv_value   = r_drvValue;
      drv_start   = r_drvStart;
      drv_ldac    = r_drvLdac;
      busy        = (r_state != IDLE);
      dirty_mask  = r_dirty;
      frame_count = r_frameCount;
      overrun     = r_overrun;
   end

endmodule

// File: tb/tb_dac_update_scheduler.sv
`timescale 1ns/1ps
// Self-checking bench for dac_update_scheduler. A simple driver model drops
// drv_idle for busyLen cycles after each start; a monitor logs every start,
// LDAC, overrun and write error; each test compares those logs against a
// channel-level model of shadows and dirty bits.
module tb_dac_update_scheduler;

   localparam int         NUM_CH = 8;
   localparam int         PERIOD = 20;
   localparam logic [3:0] CMD    = 4'h0;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        enable = 1'b0;
   logic        flush = 1'b0;
   logic        wr_valid = 1'b0;
   logic [3:0]  wr_channel = 4'h0;
   logic [15:0] wr_value = 16'h0;
   logic        drv_idle = 1'b1;
   logic        wr_err;
   logic [3:0]  drv_cmd;
   logic [3:0]  drv_channel;
   logic [15:0] drv_value;
   logic        drv_start;
   logic        drv_ldac;
   logic        busy;
   logic [7:0]  dirty_mask;
   logic [15:0] frame_count;
   logic        overrun;

   int testsRun = 0;
   int testsFailed = 0;

   int startCount = 0;
   int ldacCount = 0;
   int overrunCount = 0;
   int errCount = 0;
   int badStarts = 0;
   int lastLdacStarts = 0;
   int busyLen = 10;
   int busyCnt = 0;
   logic [3:0]  startCh[$];
   logic [15:0] startVal[$];
   logic [3:0]  startCmd[$];

   logic [15:0] mShadow [8];
   logic [7:0]  mDirty = 8'h00;
   logic [15:0] mFrames = 16'h0000;

   dac_update_scheduler #(
      .NUM_CH(NUM_CH),
      .PERIOD_CYCLES(PERIOD),
      .CMD_WRITE(CMD)
   ) dut (
      .clk(clk),
      .resetn(resetn),
      .enable(enable),
      .flush(flush),
      .wr_valid(wr_valid),
      .wr_channel(wr_channel),
      .wr_value(wr_value),
      .wr_err(wr_err),
      .drv_idle(drv_idle),
      .drv_cmd(drv_cmd),
      .drv_channel(drv_channel),
      .drv_value(drv_value),
      .drv_start(drv_start),
      .drv_ldac(drv_ldac),
      .busy(busy),
      .dirty_mask(dirty_mask),
      .frame_count(frame_count),
      .overrun(overrun)
   );

   always #5 clk = ~clk;

   // Monitor and driver model, both sampled on the inactive edge.
   initial begin
      forever begin
         @(negedge clk);
         if (drv_start) begin
            startCount++;
            startCh.push_back(drv_channel);
            startVal.push_back(drv_value);
            startCmd.push_back(drv_cmd);
            if (!drv_idle) badStarts++;
         end
         if (drv_ldac) begin
            ldacCount++;
            lastLdacStarts = startCount;
         end
         if (overrun) overrunCount++;
         if (wr_err) errCount++;
         if (drv_start) busyCnt = busyLen;
         if (busyCnt > 0) begin
            drv_idle = 1'b0;
            busyCnt--;
         end else begin
            drv_idle = 1'b1;
         end
      end
   end

   // Global time limit so the bench can never hang.
   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] time limit");
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic applyStimulus(input logic [3:0] ch, input logic [15:0] val);
      wr_valid   = 1'b1;
      wr_channel = ch;
      wr_value   = val;
      @(negedge clk);
      wr_valid   = 1'b0;
      if (ch < NUM_CH) begin
         mShadow[ch[2:0]] = val;
         mDirty[ch[2:0]]  = 1'b1;
      end
   endtask

   task automatic pulseFlush();
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
   endtask

   task automatic waitIdle(output bit ok);
      int quiet = 0;
      for (int i = 0; i < 3000 && quiet < 4; i++) begin
         @(negedge clk);
         if (busy) quiet = 0;
         else quiet++;
      end
      ok = (quiet >= 4);
   endtask

   task automatic clearLogs();
      startCh.delete();
      startVal.delete();
      startCmd.delete();
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      cycles(3);
      testsRun++;
      if ({drv_start, drv_ldac, busy, wr_err, overrun} !== 5'b0) begin
         testsFailed++;
         $display("[TB] FAIL reset_flags: got %b expected 00000", {drv_start, drv_ldac, busy, wr_err, overrun});
      end
      testsRun++;
      if (dirty_mask !== 8'h00) begin
         testsFailed++;
         $display("[TB] FAIL reset_dirty: got %h expected 00", dirty_mask);
      end
      testsRun++;
      if (frame_count !== 16'h0000) begin
         testsFailed++;
         $display("[TB] FAIL reset_frames: got %h expected 0000", frame_count);
      end
      testsRun++;
      if ({drv_cmd, drv_channel, drv_value} !== 24'h0) begin
         testsFailed++;
         $display("[TB] FAIL reset_drv: got %h expected 000000", {drv_cmd, drv_channel, drv_value});
      end
      resetn = 1'b1;
      cycles(2);
   endtask

   task automatic test_single_write();
      int baseStart = startCount;
      int baseLdac  = ldacCount;
      bit ok;
      busyLen = 10;
      clearLogs();
      applyStimulus(4'd2, 16'h1234);
      testsRun++;
      if (dirty_mask !== 8'h04) begin
         testsFailed++;
         $display("[TB] FAIL single_dirty_set: got %h expected 04", dirty_mask);
      end
      pulseFlush();
      waitIdle(ok);
      testsRun++;
      if (!ok) begin
         testsFailed++;
         $display("[TB] FAIL single_timeout: busy got 1 expected 0");
      end
      testsRun++;
      if (startCount - baseStart != 1) begin
         testsFailed++;
         $display("[TB] FAIL single_starts: got %0d expected 1", startCount - baseStart);
      end
      if (startCh.size() >= 1) begin
         testsRun++;
         if ({startCmd[0], startCh[0], startVal[0]} !== {CMD, 4'd2, 16'h1234}) begin
            testsFailed++;
            $display("[TB] FAIL single_cmd: got %h expected %h", {startCmd[0], startCh[0], startVal[0]}, {CMD, 4'd2, 16'h1234});
         end
      end
      testsRun++;
      if (ldacCount - baseLdac != 1) begin
         testsFailed++;
         $display("[TB] FAIL single_ldac: got %0d expected 1", ldacCount - baseLdac);
      end
      mFrames++;
      mDirty = 8'h00;
      testsRun++;
      if (frame_count !== mFrames) begin
         testsFailed++;
         $display("[TB] FAIL single_frames: got %0d expected %0d", frame_count, mFrames);
      end
      testsRun++;
      if (dirty_mask !== 8'h00) begin
         testsFailed++;
         $display("[TB] FAIL single_dirty_clr: got %h expected 00", dirty_mask);
      end
   endtask

   task automatic test_multi_write();
      int baseStart = startCount;
      int baseLdac  = ldacCount;
      int baseBad   = badStarts;
      logic [3:0]  expCh [3];
      logic [15:0] expVal [3];
      bit ok;
      expCh[0] = 4'd0; expVal[0] = 16'h0001;
      expCh[1] = 4'd5; expVal[1] = 16'hBEEF;
      expCh[2] = 4'd7; expVal[2] = 16'hFFFF;
      busyLen = 10;
      clearLogs();
      applyStimulus(4'd7, 16'hFFFF);
      applyStimulus(4'd0, 16'h0001);
      applyStimulus(4'd5, 16'hBEEF);
      pulseFlush();
      waitIdle(ok);
      testsRun++;
      if (!ok || startCh.size() != 3) begin
         testsFailed++;
         $display("[TB] FAIL multi_starts: got %0d starts expected 3", startCh.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            testsRun++;
            if ({startCh[i], startVal[i]} !== {expCh[i], expVal[i]}) begin
               testsFailed++;
               $display("[TB] FAIL multi_order%0d: got %h expected %h", i, {startCh[i], startVal[i]}, {expCh[i], expVal[i]});
            end
         end
      end
      testsRun++;
      if (badStarts != baseBad) begin
         testsFailed++;
         $display("[TB] FAIL multi_handshake: got %0d early starts expected 0", badStarts - baseBad);
      end
      testsRun++;
      if (ldacCount - baseLdac != 1 || lastLdacStarts != baseStart + 3) begin
         testsFailed++;
         $display("[TB] FAIL multi_ldac: got %0d pulses after %0d starts expected 1 after %0d", ldacCount - baseLdac, lastLdacStarts, baseStart + 3);
      end
      mFrames++;
      mDirty = 8'h00;
      testsRun++;
      if (frame_count !== mFrames) begin
         testsFailed++;
         $display("[TB] FAIL multi_frames: got %0d expected %0d", frame_count, mFrames);
      end
   endtask

   task automatic test_empty_flush();
      int baseStart = startCount;
      int baseLdac  = ldacCount;
      int busyCycles = 0;
      pulseFlush();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (busy) busyCycles++;
      end
      testsRun++;
      if (busyCycles > 1) begin
         testsFailed++;
         $display("[TB] FAIL empty_busy: got %0d cycles expected at most 1", busyCycles);
      end
      testsRun++;
      if (startCount != baseStart || ldacCount != baseLdac) begin
         testsFailed++;
         $display("[TB] FAIL empty_activity: got %0d starts %0d ldac expected 0 0", startCount - baseStart, ldacCount - baseLdac);
      end
      testsRun++;
      if (frame_count !== mFrames) begin
         testsFailed++;
         $display("[TB] FAIL empty_frames: got %0d expected %0d", frame_count, mFrames);
      end
   endtask

   task automatic test_overrun();
      int baseStart = startCount;
      int baseLdac  = ldacCount;
      int baseOvr   = overrunCount;
      bit seen = 0;
      bit ok;
      busyLen = 45;
      clearLogs();
      applyStimulus(4'd1, 16'hC001);
      enable = 1'b1;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         if (startCount > baseStart) seen = 1;
      end
      testsRun++;
      if (!seen) begin
         testsFailed++;
         $display("[TB] FAIL ovr_first_start: got 0 starts expected 1");
      end
      applyStimulus(4'd0, 16'h5A5A);
      seen = 0;
      for (int i = 0; i < 100 && !seen; i++) begin
         if (overrunCount > baseOvr) seen = 1;
         else @(negedge clk);
      end
      enable = 1'b0;
      testsRun++;
      if (!seen) begin
         testsFailed++;
         $display("[TB] FAIL ovr_pulse: got 0 overruns expected 1");
      end
      waitIdle(ok);
      cycles(40);
      testsRun++;
      if (!ok || overrunCount - baseOvr != 1) begin
         testsFailed++;
         $display("[TB] FAIL ovr_count: got %0d expected 1", overrunCount - baseOvr);
      end
      testsRun++;
      if (ldacCount - baseLdac != 2 || startCount - baseStart != 2) begin
         testsFailed++;
         $display("[TB] FAIL ovr_frames: got %0d ldac %0d starts expected 2 2", ldacCount - baseLdac, startCount - baseStart);
      end
      if (startCh.size() == 2) begin
         testsRun++;
         if ({startCh[0], startVal[0], startCh[1], startVal[1]} !== {4'd1, 16'hC001, 4'd0, 16'h5A5A}) begin
            testsFailed++;
            $display("[TB] FAIL ovr_order: got %h expected %h", {startCh[0], startVal[0], startCh[1], startVal[1]}, {4'd1, 16'hC001, 4'd0, 16'h5A5A});
         end
      end
      mFrames = mFrames + 16'd2;
      mDirty = 8'h00;
      testsRun++;
      if (frame_count !== mFrames) begin
         testsFailed++;
         $display("[TB] FAIL ovr_framecount: got %0d expected %0d", frame_count, mFrames);
      end
   endtask

   task automatic test_same_cycle_write();
      bit found = 0;
      bit ok;
      busyLen = 3;
      clearLogs();
      applyStimulus(4'd3, 16'h0AAA);
      pulseFlush();
      for (int i = 0; i < 50 && !found; i++) begin
         @(negedge clk);
         if (drv_start && drv_channel == 4'd3) found = 1;
      end
      testsRun++;
      if (!found) begin
         testsFailed++;
         $display("[TB] FAIL same_issue: got no start on ch3 expected one");
      end
      applyStimulus(4'd3, 16'h1111);
      waitIdle(ok);
      mFrames++;
      testsRun++;
      if (!ok || startVal.size() != 1 || startVal[0] !== 16'h0AAA) begin
         testsFailed++;
         $display("[TB] FAIL same_old_value: got %0d starts first %h expected 1 start 0aaa", startVal.size(), (startVal.size() > 0) ? startVal[0] : 16'h0);
      end
      testsRun++;
      if (dirty_mask !== 8'h08) begin
         testsFailed++;
         $display("[TB] FAIL same_still_dirty: got %h expected 08", dirty_mask);
      end
      clearLogs();
      pulseFlush();
      waitIdle(ok);
      mFrames++;
      mDirty = 8'h00;
      testsRun++;
      if (!ok || startVal.size() != 1 || startVal[0] !== 16'h1111) begin
         testsFailed++;
         $display("[TB] FAIL same_new_value: got %0d starts first %h expected 1 start 1111", startVal.size(), (startVal.size() > 0) ? startVal[0] : 16'h0);
      end
      testsRun++;
      if (frame_count !== mFrames) begin
         testsFailed++;
         $display("[TB] FAIL same_frames: got %0d expected %0d", frame_count, mFrames);
      end
   endtask

   task automatic test_bad_channel();
      int baseErr = errCount;
      applyStimulus(4'd6, 16'h6666);
      applyStimulus(4'd9, 16'hDEAD);
      testsRun++;
      if (wr_err !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL bad_err_pulse: got %b expected 1", wr_err);
      end
      cycles(1);
      testsRun++;
      if (wr_err !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL bad_err_width: got %b expected 0", wr_err);
      end
      applyStimulus(4'd8, 16'hBAD8);
      cycles(1);
      testsRun++;
      if (errCount - baseErr != 2) begin
         testsFailed++;
         $display("[TB] FAIL bad_err_count: got %0d expected 2", errCount - baseErr);
      end
      testsRun++;
      if (dirty_mask !== mDirty) begin
         testsFailed++;
         $display("[TB] FAIL bad_dirty: got %h expected %h", dirty_mask, mDirty);
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 8; it++) begin
         int baseLdac = ldacCount;
         int baseErr  = errCount;
         int nWrites  = $urandom_range(0, 5);
         int invalid  = 0;
         logic [3:0]  expCh[$];
         logic [15:0] expVal[$];
         bit ok;
         busyLen = $urandom_range(0, 6);
         clearLogs();
         for (int w = 0; w < nWrites; w++) begin
            logic [3:0]  ch  = 4'($urandom_range(0, 9));
            logic [15:0] val = 16'($urandom);
            if (ch >= NUM_CH) invalid++;
            applyStimulus(ch, val);
         end
         for (int c = 0; c < NUM_CH; c++) begin
            if (mDirty[c]) begin
               expCh.push_back(4'(c));
               expVal.push_back(mShadow[c]);
            end
         end
         pulseFlush();
         waitIdle(ok);
         testsRun++;
         if (!ok || startCh.size() != expCh.size()) begin
            testsFailed++;
            $display("[TB] FAIL rand%0d_count: got %0d starts expected %0d", it, startCh.size(), expCh.size());
         end else begin
            for (int i = 0; i < expCh.size(); i++) begin
               testsRun++;
               if ({startCmd[i], startCh[i], startVal[i]} !== {CMD, expCh[i], expVal[i]}) begin
                  testsFailed++;
                  $display("[TB] FAIL rand%0d_cmd%0d: got %h expected %h", it, i, {startCmd[i], startCh[i], startVal[i]}, {CMD, expCh[i], expVal[i]});
               end
            end
         end
         if (expCh.size() > 0) mFrames++;
         mDirty = 8'h00;
         testsRun++;
         if (ldacCount - baseLdac != ((expCh.size() > 0) ? 1 : 0) || frame_count !== mFrames) begin
            testsFailed++;
            $display("[TB] FAIL rand%0d_ldac: got %0d pulses count %0d expected frames %0d", it, ldacCount - baseLdac, frame_count, mFrames);
         end
         testsRun++;
         if (errCount - baseErr != invalid || dirty_mask !== 8'h00) begin
            testsFailed++;
            $display("[TB] FAIL rand%0d_err: got %0d errs dirty %h expected %0d errs dirty 00", it, errCount - baseErr, dirty_mask, invalid);
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      int baseStart = startCount;
      int baseLdac;
      bit seen = 0;
      busyLen = 20;
      applyStimulus(4'd4, 16'h4444);
      pulseFlush();
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         if (startCount > baseStart) seen = 1;
      end
      testsRun++;
      if (!seen) begin
         testsFailed++;
         $display("[TB] FAIL rstmid_start: got 0 starts expected 1");
      end
      cycles(2);
      resetn = 1'b0;
      baseLdac = ldacCount;
      @(negedge clk);
      testsRun++;
      if ({drv_start, drv_ldac, busy, wr_err, overrun} !== 5'b0 || dirty_mask !== 8'h00 || frame_count !== 16'h0) begin
         testsFailed++;
         $display("[TB] FAIL rstmid_state: got flags %b dirty %h frames %h expected 0", {drv_start, drv_ldac, busy, wr_err, overrun}, dirty_mask, frame_count);
      end
      testsRun++;
      if ({drv_cmd, drv_channel, drv_value} !== 24'h0) begin
         testsFailed++;
         $display("[TB] FAIL rstmid_drv: got %h expected 000000", {drv_cmd, drv_channel, drv_value});
      end
      resetn = 1'b1;
      mDirty = 8'h00;
      mFrames = 16'h0000;
      for (int c = 0; c < 8; c++) mShadow[c] = 16'h0000;
      cycles(40);
      testsRun++;
      if (ldacCount != baseLdac || busy !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL rstmid_no_ldac: got %0d pulses busy %b expected 0 0", ldacCount - baseLdac, busy);
      end
   endtask

   // Test sequence.
   initial begin
      for (int c = 0; c < 8; c++) mShadow[c] = 16'h0000;
      @(negedge clk);
      test_reset();
      test_single_write();
      test_multi_write();
      test_empty_flush();
      test_overrun();
      test_same_cycle_write();
      test_bad_channel();
      test_random();
      test_reset_mid_frame();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
